// File: rtl/net_word_serial.sv
// Word-oriented 8N1 serial transceiver: sends a 32-bit word as four LSB-first bytes
// and reassembles four received bytes into a word, with overrun/framing/timeout handling.
module net_word_serial #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [31:0] tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        serial_tx,
  input  logic        serial_rx,
  input  logic        rx_ack,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  state_t          tx_state_r, tx_state_s;
  logic [CW-1:0]   tx_cnt_r, tx_cnt_s;
  logic [2:0]      tx_bit_r, tx_bit_s;
  logic [1:0]      tx_byte_r, tx_byte_s;
  logic [31:0]     tx_shift_r, tx_shift_s;
  logic            tx_line_r, tx_line_s;
  logic            tx_busy_r, tx_busy_s;
  logic            tx_done_r, tx_done_s;

  // TX next-state: each frame slot lasts CLKS_PER_BIT cycles; bytes run back-to-back.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_byte_s  = tx_byte_r;
    tx_shift_s = tx_shift_r;
    tx_done_s  = 1'b0;
    case (tx_state_r)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_s = ST_START;
          tx_cnt_s   = CNT_ZERO;
          tx_bit_s   = 3'd0;
          tx_byte_s  = 2'd0;
          tx_shift_s = tx_data;
        end else begin
          tx_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_state_s = ST_DATA;
          tx_cnt_s   = CNT_ZERO;
          tx_bit_s   = 3'd0;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = CNT_ZERO;
          tx_shift_s = {1'b0, tx_shift_r[31:1]};
          if (tx_bit_r == 3'd7) begin
            tx_state_s = ST_STOP;
          end else begin
            tx_bit_s = tx_bit_r + 3'd1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_byte_r == 2'd3) begin
            tx_state_s = ST_IDLE;
            tx_done_s  = 1'b1;
          end else begin
            tx_byte_s  = tx_byte_r + 2'd1;
            tx_state_s = ST_START;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: tx_state_s = ST_IDLE;
    endcase
    // Line level is decoded from the next state so serial_tx is a plain register.
    case (tx_state_s)
      ST_START: tx_line_s = 1'b0;
      ST_DATA:  tx_line_s = tx_shift_s[0];
      default:  tx_line_s = 1'b1;
    endcase
    tx_busy_s = (tx_state_s != ST_IDLE);
  end

  // TX state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_byte_r  <= 2'd0;
      tx_shift_r <= 32'd0;
      tx_line_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_byte_r  <= tx_byte_s;
      tx_shift_r <= tx_shift_s;
      tx_line_r  <= tx_line_s;
      tx_busy_r  <= tx_busy_s;
      tx_done_r  <= tx_done_s;
    end
  end

  assign serial_tx = tx_line_r;
  assign tx_busy   = tx_busy_r;
  assign tx_done   = tx_done_r;

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  state_t          rx_state_r, rx_state_s;
  logic [CW-1:0]   rx_cnt_r, rx_cnt_s;
  logic [CW-1:0]   rx_tmo_r, rx_tmo_s;
  logic [2:0]      rx_bit_r, rx_bit_s;
  logic [7:0]      rx_shift_r, rx_shift_s;
  logic [1:0]      rx_byte_cnt_r, rx_byte_cnt_s;
  logic [23:0]     rx_word_r, rx_word_s;
  logic            rx_valid_r, rx_valid_s;
  logic [31:0]     rx_data_r, rx_data_s;
  logic            rx_ovr_r, rx_ovr_s;
  logic            rx_ferr_r, rx_ferr_s;
  logic            byte_good_s, byte_bad_s, word_done_s;

  // RX next-state: start re-check at half bit, then one sample per bit period.
  always_comb begin
    rx_state_s    = rx_state_r;
    rx_cnt_s      = rx_cnt_r;
    rx_tmo_s      = rx_tmo_r;
    rx_bit_s      = rx_bit_r;
    rx_shift_s    = rx_shift_r;
    rx_byte_cnt_s = rx_byte_cnt_r;
    rx_word_s     = rx_word_r;
    byte_good_s   = 1'b0;
    byte_bad_s    = 1'b0;
    word_done_s   = 1'b0;
    case (rx_state_r)
      ST_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = ST_START;
          rx_cnt_s   = CNT_ZERO;
          rx_tmo_s   = CNT_ZERO;
        end else if (rx_byte_cnt_r != 2'd0) begin
          if (rx_tmo_r == TMO_LAST) begin
            rx_byte_cnt_s = 2'd0;
            rx_tmo_s      = CNT_ZERO;
          end else begin
            rx_tmo_s = rx_tmo_r + CNT_ONE;
          end
        end else begin
          rx_tmo_s = CNT_ZERO;
        end
      end
      ST_START: begin
        if (rx_cnt_r == BIT_HALF) begin
          rx_cnt_s = CNT_ZERO;
          rx_bit_s = 3'd0;
          if (!rx_sync_r) begin
            rx_state_s = ST_DATA;
          end else begin
            rx_state_s = ST_IDLE;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = ST_STOP;
          end else begin
            rx_bit_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = ST_IDLE;
          if (rx_sync_r) begin
            byte_good_s = 1'b1;
          end else begin
            byte_bad_s = 1'b1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      default: rx_state_s = ST_IDLE;
    endcase

    if (byte_good_s) begin
      case (rx_byte_cnt_r)
        2'd0:    rx_word_s[7:0]   = rx_shift_r;
        2'd1:    rx_word_s[15:8]  = rx_shift_r;
        2'd2:    rx_word_s[23:16] = rx_shift_r;
        default: word_done_s      = 1'b1;
      endcase
      rx_byte_cnt_s = rx_byte_cnt_r + 2'd1;
    end else if (byte_bad_s) begin
      rx_byte_cnt_s = 2'd0;
    end else begin
      rx_word_s = rx_word_r;
    end

    // A completing word beats a simultaneous ack; ack still clears the sticky flags.
    rx_valid_s = word_done_s | (rx_valid_r & ~rx_ack);
    rx_data_s  = word_done_s ? {rx_shift_r, rx_word_r} : rx_data_r;
    rx_ovr_s   = (rx_ovr_r & ~rx_ack) | (word_done_s & rx_valid_r & ~rx_ack);
    rx_ferr_s  = byte_bad_s | (rx_ferr_r & ~rx_ack);
  end

  // RX synchroniser, state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r     <= 1'b1;
      rx_sync_r     <= 1'b1;
      rx_prev_r     <= 1'b1;
      rx_state_r    <= ST_IDLE;
      rx_cnt_r      <= CNT_ZERO;
      rx_tmo_r      <= CNT_ZERO;
      rx_bit_r      <= 3'd0;
      rx_shift_r    <= 8'd0;
      rx_byte_cnt_r <= 2'd0;
      rx_word_r     <= 24'd0;
      rx_valid_r    <= 1'b0;
      rx_data_r     <= 32'd0;
      rx_ovr_r      <= 1'b0;
      rx_ferr_r     <= 1'b0;
    end else begin
      rx_meta_r     <= serial_rx;
      rx_sync_r     <= rx_meta_r;
      rx_prev_r     <= rx_sync_r;
      rx_state_r    <= rx_state_s;
      rx_cnt_r      <= rx_cnt_s;
      rx_tmo_r      <= rx_tmo_s;
      rx_bit_r      <= rx_bit_s;
      rx_shift_r    <= rx_shift_s;
      rx_byte_cnt_r <= rx_byte_cnt_s;
      rx_word_r     <= rx_word_s;
      rx_valid_r    <= rx_valid_s;
      rx_data_r     <= rx_data_s;
      rx_ovr_r      <= rx_ovr_s;
      rx_ferr_r     <= rx_ferr_s;
    end
  end

  assign rx_valid     = rx_valid_r;
  assign rx_data      = rx_data_r;
  assign rx_overrun   = rx_ovr_r;
  assign rx_frame_err = rx_ferr_r;

endmodule
